// File: rtl/csr_exec.sv
// CSR instruction sequencer: decodes one SYSTEM-opcode CSR op, reads the old value,
// issues a single write/set/clear strobe, and returns the old value on a writeback handshake.
module csr_exec #(
    parameter int unsigned XLEN     = 32,
    parameter bit          RO_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    output logic [11:0]     csr_imm,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_rw,
    output logic            csr_rs,
    output logic            csr_rc,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic            illegal,
    output logic            ins_counter_up
);

    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e          state_q, state_d;
    logic [4:0]      rd_q;
    logic [4:0]      src_q;
    logic [2:0]      f3_q;
    logic [11:0]     csr_imm_q;
    logic [XLEN-1:0] csr_wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            illegal_q;

    logic            accept;
    logic [2:0]      in_f3;
    logic            in_legal;
    logic            do_write;
    logic            ro_viol;
    logic            strobe_en;

    assign in_f3  = instr[14:12];
    // f3 of 000 or 100 is not a CSR op; both have f3[1:0] == 0.
    assign in_legal = (instr[6:0] == OpSystem) && (in_f3[1:0] != 2'b00);
    assign accept   = in_valid && in_ready;

    // Set/clear with a zero source never modifies the CSR, so it never strobes.
    assign do_write  = (f3_q[1:0] == 2'b01) || (src_q != 5'd0);
    assign ro_viol   = RO_CHECK && do_write && (csr_imm_q[11:10] == 2'b11);
    assign strobe_en = (state_q == StWrite) && do_write && !ro_viol;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = in_legal ? StRead : StResp;
                end
            end
            StRead:  state_d = StWrite;
            StWrite: state_d = StResp;
            StResp: begin
                if (wb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q        <= '0;
            src_q       <= '0;
            f3_q        <= '0;
            csr_imm_q   <= '0;
            csr_wdata_q <= '0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (accept) begin
                rd_q        <= instr[11:7];
                src_q       <= instr[19:15];
                f3_q        <= in_f3;
                csr_imm_q   <= instr[31:20];
                csr_wdata_q <= in_f3[2] ? {{(XLEN-5){1'b0}}, instr[19:15]} : rs1_data;
                illegal_q   <= !in_legal;
            end
            if (state_q == StRead) begin
                rdata_q <= csr_rdata;
            end
            if (state_q == StWrite && ro_viol) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Gated by reset so the core sees no ready while the block is held in reset.
    assign in_ready = reset && (state_q == StIdle);

    assign csr_imm   = csr_imm_q;
    assign csr_wdata = csr_wdata_q;

    // Strobes decode from state, so an asynchronous reset drops them at once.
    assign csr_rw = strobe_en && (f3_q[1:0] == 2'b01);
    assign csr_rs = strobe_en && (f3_q[1:0] == 2'b10);
    assign csr_rc = strobe_en && (f3_q[1:0] == 2'b11);

    assign wb_valid       = (state_q == StResp);
    assign wb_rd          = wb_valid ? rd_q : 5'd0;
    assign wb_data        = (wb_valid && !illegal_q) ? rdata_q : '0;
    assign wb_we          = wb_valid && (rd_q != 5'd0) && !illegal_q;
    assign illegal        = wb_valid && illegal_q;
    assign ins_counter_up = wb_valid && wb_ready && !illegal_q;

endmodule

// File: tb/tb_csr_exec.sv
// Bench for csr_exec: small CSR file stand-in plus an instruction-level reference model,
// directed cases followed by randomized instructions.
module tb_csr_exec;

    localparam int unsigned XLEN = 32;
    localparam logic [6:0]  SYS  = 7'b1110011;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic            wb_ready = 1'b0;
    logic [XLEN-1:0] csr_rdata;

    logic            in_ready, csr_rw, csr_rs, csr_rc, wb_valid, wb_we, illegal, icu;
    logic [11:0]     csr_imm;
    logic [XLEN-1:0] csr_wdata, wb_data;
    logic [4:0]      wb_rd;

    logic            n_in_ready, n_csr_rw, n_csr_rs, n_csr_rc, n_wb_valid, n_wb_we;
    logic            n_illegal, n_icu;
    logic [11:0]     n_csr_imm;
    logic [XLEN-1:0] n_csr_wdata, n_wb_data;
    logic [4:0]      n_wb_rd;

    int total = 0;
    int bad = 0;
    logic chk_nro = 1'b0;

    always #5 clk = ~clk;

    csr_exec #(.XLEN(XLEN), .RO_CHECK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .csr_imm(csr_imm), .csr_wdata(csr_wdata), .csr_rw(csr_rw),
        .csr_rs(csr_rs), .csr_rc(csr_rc), .csr_rdata(csr_rdata), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
        .illegal(illegal), .ins_counter_up(icu)
    );

    // Same stimulus, no read-only check; stays in lockstep since legal ops take fixed cycles.
    csr_exec #(.XLEN(XLEN), .RO_CHECK(1'b0)) u_dut_nro (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
        .rs1_data(rs1_data), .csr_imm(n_csr_imm), .csr_wdata(n_csr_wdata), .csr_rw(n_csr_rw),
        .csr_rs(n_csr_rs), .csr_rc(n_csr_rc), .csr_rdata(csr_rdata), .wb_valid(n_wb_valid),
        .wb_ready(wb_ready), .wb_rd(n_wb_rd), .wb_data(n_wb_data), .wb_we(n_wb_we),
        .illegal(n_illegal), .ins_counter_up(n_icu)
    );

    // CSR file stand-in: FFLAGS, FRM, FCSR, MSCRATCH implemented; CYCLE at 0xC00.
    logic [31:0] cyc = '0;
    logic [31:0] cf [4];
    logic [31:0] ref_cf [4];
    logic        pl_en = 1'b0;
    logic [1:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [2:0]  rd_map, wr_map;

    function automatic logic [2:0] cmap(input logic [11:0] a);
        case (a)
            12'h001: return 3'b100;
            12'h002: return 3'b101;
            12'h003: return 3'b110;
            12'h340: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 32'd1;

    always_comb begin
        rd_map = cmap(csr_imm);
        csr_rdata = '0;
        if (csr_imm == 12'hC00) csr_rdata = cyc;
        else if (rd_map[2]) csr_rdata = cf[rd_map[1:0]];
    end

    always @(posedge clk) begin
        wr_map = cmap(csr_imm);
        if (pl_en) cf[pl_idx] <= pl_data;
        else if (wr_map[2]) begin
            if (csr_rw) cf[wr_map[1:0]] <= csr_wdata;
            else if (csr_rs) cf[wr_map[1:0]] <= cf[wr_map[1:0]] | csr_wdata;
            else if (csr_rc) cf[wr_map[1:0]] <= cf[wr_map[1:0]] & ~csr_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_cf[idx] = val;
    endtask

    function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] src,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {a, src, f3, rd, op};
    endfunction

    // Issue one instruction and check every cycle until it retires, against the model.
    task automatic do_instr(input logic [31:0] ins, input logic [31:0] rs1, input int hold);
        logic [2:0] f3;
        logic [4:0] rd, src;
        logic [11:0] a;
        logic legal, dw, ro, ill;
        logic [31:0] opnd, old;
        logic [2:0] m, exp_stb;
        int lat;
        f3  = ins[14:12];
        rd  = ins[11:7];
        src = ins[19:15];
        a   = ins[31:20];
        legal = (ins[6:0] == SYS) && (f3 != 3'b000) && (f3 != 3'b100);
        opnd  = f3[2] ? {27'd0, src} : rs1;
        dw    = (f3[1:0] == 2'b01) || (src != 5'd0);
        ro    = legal && dw && (a[11:10] == 2'b11);
        ill   = !legal || ro;
        exp_stb = 3'b000;
        if (legal && dw && !ro) exp_stb = 3'b001 << (f3[1:0] - 2'd1);
        lat = legal ? 3 : 1;
        m = cmap(a);

        @(negedge clk);
        in_valid = 1'b1; instr = ins; rs1_data = rs1;
        #1 chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; instr = $urandom; rs1_data = $urandom;
        // cyc here is the counter value seen during the READ cycle
        old = (a == 12'hC00) ? cyc : (m[2] ? ref_cf[m[1:0]] : 32'd0);
        if (m[2]) begin
            if (exp_stb == 3'b001) ref_cf[m[1:0]] = opnd;
            else if (exp_stb == 3'b010) ref_cf[m[1:0]] = old | opnd;
            else if (exp_stb == 3'b100) ref_cf[m[1:0]] = old & ~opnd;
        end

        for (int k = 1; k < lat; k++) begin
            chk("strobes", {29'd0, csr_rc, csr_rs, csr_rw}, {29'd0, (k == 2) ? exp_stb : 3'b000});
            if (k == 2 && exp_stb != 3'b000) begin
                chk("csr_wdata", csr_wdata, opnd);
                chk("csr_imm", {20'd0, csr_imm}, {20'd0, a});
            end
            if (k == 2 && chk_nro) chk("nro_csr_rw", {31'd0, n_csr_rw}, 32'd1);
            chk("wb_valid_early", {31'd0, wb_valid}, 32'd0);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end

        for (int h = 0; h <= hold; h++) begin
            if (h == hold) begin
                wb_ready = 1'b1;
                #1;
            end
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wb_data", wb_data, ill ? 32'd0 : old);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
            chk("wb_we", {31'd0, wb_we}, {31'd0, (rd != 5'd0) && !ill});
            chk("illegal", {31'd0, illegal}, {31'd0, ill});
            chk("strobes_resp", {29'd0, csr_rc, csr_rs, csr_rw}, 32'd0);
            chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
            chk("icu", {31'd0, icu}, {31'd0, (h == hold) && !ill});
            if (h < hold) @(negedge clk);
        end
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        chk("wb_valid_after", {31'd0, wb_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("icu_after", {31'd0, icu}, 32'd0);
        if (m[2]) chk("csr_file", cf[m[1:0]], ref_cf[m[1:0]]);
    endtask

    logic [11:0] alist [7];
    logic [31:0] ins_r;

    initial begin
        alist = '{12'h001, 12'h002, 12'h003, 12'h340, 12'hC00, 12'hC01, 12'h7C0};

        // reset held low for 3 cycles; preloads do not depend on reset
        preload(2'd0, 32'h5);
        preload(2'd1, 32'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_strobes", {29'd0, csr_rc, csr_rs, csr_rw}, 32'd0);
            chk("rst_csr_imm", {20'd0, csr_imm}, 32'd0);
            chk("rst_csr_wdata", csr_wdata, 32'd0);
            chk("rst_wb", {wb_data[25:0], wb_rd, wb_valid}, 32'd0);
            chk("rst_flags", {29'd0, wb_we, illegal, icu}, 32'd0);
        end
        preload(2'd2, 32'h5A);
        preload(2'd3, 32'h0);
        reset = 1'b1;
        #1 chk("in_ready_post_rst", {31'd0, in_ready}, 32'd1);

        // CSRRS x3, fflags, x1 with x1=0xA
        do_instr(enc(12'h001, 5'd1, 3'b010, 5'd3, SYS), 32'hA, 0);
        chk("fflags_or", cf[0], 32'hF);
        // CSRRCI x4, frm, 0 and CSRRS x5, frm, x0: no strobes
        do_instr(enc(12'h002, 5'd0, 3'b111, 5'd4, SYS), 32'hFFFF_FFFF, 0);
        do_instr(enc(12'h002, 5'd0, 3'b010, 5'd5, SYS), 32'hFFFF_FFFF, 1);
        // CSRRW x6, cycle, x5: illegal here, strobed by the unchecked instance
        chk_nro = 1'b1;
        do_instr(enc(12'hC00, 5'd5, 3'b001, 5'd6, SYS), 32'h1234, 0);
        chk_nro = 1'b0;
        // RDCYCLE via CSRRS x7, cycle, x0
        do_instr(enc(12'hC00, 5'd0, 3'b010, 5'd7, SYS), 32'h0, 0);
        // CSRRW with writeback stalled 4 cycles
        do_instr(enc(12'h340, 5'd2, 3'b001, 5'd8, SYS), 32'hCAFE_F00D, 4);
        // ADD: not a SYSTEM op
        do_instr(enc(12'h000, 5'd2, 3'b000, 5'd9, 7'b0110011), 32'h1, 0);
        // CSRRW to x0: legal, no rd write
        do_instr(enc(12'h003, 5'd3, 3'b001, 5'd0, SYS), 32'h77, 0);

        for (int i = 0; i < 40; i++) begin
            ins_r = enc(alist[$urandom_range(0, 6)],
                        ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                        3'($urandom), 5'($urandom),
                        ($urandom_range(0, 7) == 0) ? 7'b0110011 : SYS);
            do_instr(ins_r, $urandom, int'($urandom_range(0, 3)));
        end

        // reset asserted during WRITE of CSRRW to fcsr
        @(negedge clk);
        in_valid = 1'b1;
        instr = enc(12'h003, 5'd9, 3'b001, 5'd2, SYS);
        rs1_data = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_rw_high", {31'd0, csr_rw}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_rw_drop", {31'd0, csr_rw}, 32'd0);
        chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mid_csr_imm", {20'd0, csr_imm}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("rst_mid_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid_no_icu", {31'd0, icu}, 32'd0);
        chk("rst_mid_fcsr", cf[2], ref_cf[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_exec.md
Name: csr_exec

Overview:
- Upstream control stage for the core's CSR register file.
- Accepts one decoded SYSTEM-opcode instruction at a time and drives the CSR file's address, write data and rw/rs/rc strobes.
- Captures the old CSR value (read-before-write) and returns it on a writeback handshake to the register file.
- Pulses ins_counter_up once per retired CSR instruction, so RDINSTRET counts CSR retirements.

Parameters:
XLEN, 32, datapath width of rs1_data, csr_wdata, csr_rdata and wb_data.
RO_CHECK, 1, when 1 a write attempt to address[11:10]==2'b11 is illegal; when 0 the strobe is issued anyway.

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset; low clears all state immediately.
in_valid  input  1  instruction offered.
in_ready  output  1  high only in IDLE.
instr  input  32  raw instruction word.
rs1_data  input  XLEN  value of x[rs1], sampled at accept.
csr_imm  output  12  CSR address to CSR file, registered.
csr_wdata  output  XLEN  write/set/clear operand, registered.
csr_rw  output  1  write strobe, one cycle.
csr_rs  output  1  set strobe, one cycle.
csr_rc  output  1  clear strobe, one cycle.
csr_rdata  input  XLEN  combinational read data from CSR file.
wb_valid  output  1  result available.
wb_ready  input  1  writeback accepted.
wb_rd  output  5  destination register.
wb_data  output  XLEN  old CSR value.
wb_we  output  1  write rd (0 if rd==0 or illegal).
illegal  output  1  valid with wb_valid; illegal instruction.
ins_counter_up  output  1  one-cycle retirement pulse.

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset: state=IDLE; every output and internal register is 0, including csr_imm, csr_wdata, strobes, wb_*, illegal and ins_counter_up. in_ready is 0 while reset is low and 1 in IDLE after reset releases.
- IDLE: accept on in_valid&&in_ready at edge N.
  - Latch rd=instr[11:7], f3=instr[14:12], src=instr[19:15] and csr_imm=instr[31:20].
  - csr_wdata = rs1_data when f3[2]==0; otherwise {(XLEN-5)'b0, src}.
  - Legal CSR op: opcode==7'b1110011 and f3 not in {000,100}. Legal op goes to READ.
  - Any other instruction goes directly to RESP with illegal=1 and wb_we=0.
- READ (cycle N+1): all strobes low; rdata_q <= csr_rdata at end of cycle. Move to WRITE.
- WRITE (cycle N+2):
  - do_write = (f3[1:0]==01) or (src!=0). CSRRS/CSRRC/CSRRSI/CSRRCI with src==0 never strobe.
  - If do_write and RO_CHECK and csr_imm[11:10]==2'b11: no strobe, illegal=1.
  - Else if do_write: exactly one of csr_rw (f3[1:0]=01), csr_rs (10) or csr_rc (11) is high for this single cycle.
  - Unimplemented address: no trap; reads return 0 per CSR file.
  - Move to RESP.
- RESP (N+3 onward): wb_valid=1, wb_data=rdata_q (0 if illegal), wb_rd=rd, wb_we=(rd!=0)&&!illegal. All fields are held stable while wb_ready is low.
  - On wb_valid&&wb_ready: go to IDLE the next cycle. ins_counter_up=1 for exactly that cycle if !illegal, else 0.
- Latency: accept to wb_valid is 3 cycles for a legal op, 1 cycle for a non-CSR op. Throughput: at most one instruction in flight.
- Counters: the value returned for C00–C82 is the counter value during the READ cycle.
- Reset low mid-operation: abort immediately, strobes drop asynchronously, nothing retires, no pulse.
- Strobes are never asserted outside WRITE; at most one strobe is high per cycle.

Test Plan:
- Reset held low for 3 cycles, then released → all outputs 0 during reset; in_ready=1 on the first cycle after release; no strobes.
- FFLAGS preloaded to 0x5; CSRRS rd=x3, csr=0x001, rs1_data=0xA → csr_rs high for exactly 1 cycle with csr_wdata=0xA, 2 cycles after accept; wb_valid at +3 with wb_data=0x5, wb_rd=3, wb_we=1; FFLAGS becomes 0xF; ins_counter_up pulses once.
- CSRRCI csr=0x002 with uimm=0, then CSRRS with rs1 field=0 → no strobe in either case; wb_data = current FRM value.
- CSRRW csr=0xC00, rs1 field=5 → illegal=1, no strobe, wb_we=0, wb_data=0, no ins_counter_up. With RO_CHECK=0 → csr_rw issued. CSRRS csr=0xC00, src=0 → legal, wb_data=RDCYCLE[31:0] sampled in READ.
- wb_ready held low 4 cycles in RESP → wb_* fields stable, in_ready=0; single ins_counter_up on the handshake cycle. Non-SYSTEM instruction (opcode 0110011) → wb_valid next cycle with illegal=1.
- Reset driven low during WRITE of a CSRRW to 0x003 → csr_rw drops immediately, FCAR unchanged, state=IDLE after release, no wb_valid.
